// File: rtl/control_pkg.sv
// Shared definitions for the SPI command front-end: channel IDs, FSM states,
// and bit positions inside the status byte and the err_flags vector.
// CTRL_PARITY_EN adds the PARITY state used for the frame trailer check.
package control_pkg;

   localparam logic [1:0] SHA_ID = 2'd1;
   localparam logic [1:0] AES_ID = 2'd2;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_HDR,
      ST_PAYLOAD,
      ST_DISCARD,
      ST_STATUS
`ifdef CTRL_PARITY_EN
      ,
      ST_PARITY
`endif
   } state_t;

   // status byte bit positions
   localparam int STS_BUSY   = 7;
   localparam int STS_OVF    = 6;
   localparam int STS_ABORT  = 5;
   localparam int STS_BAD_ID = 4;
   localparam int STS_PAR    = 3;

   // err_flags bit positions
   localparam int ERR_OVF    = 4;
   localparam int ERR_ABORT  = 3;
   localparam int ERR_BAD_ID = 2;
   localparam int ERR_PAR    = 1;
   localparam int ERR_BUSY   = 0;

endpackage

// File: rtl/ctrl_byte_fifo.sv
// Payload FIFO holding {last, data} entries. A flush discards everything
// except the head entry, which stays readable so an in-flight transfer can
// complete; a pop in the same cycle as a flush empties the FIFO.
module ctrl_byte_fifo #(
   parameter int DEPTH = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       push,
   input  logic [8:0] wdata,
   input  logic       pop,
   input  logic       flush,
   output logic [8:0] rdata,
   output logic       full,
   output logic       empty,
   output logic       single
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [8:0]    mem [DEPTH];
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   logic [AW:0]   cnt;
   logic          do_pop;
   logic          do_push;

   assign empty   = (cnt == '0);
   assign full    = (cnt == (AW+1)'(DEPTH));
   assign single  = (cnt == (AW+1)'(1));
   assign do_pop  = pop && !empty;
   // a pop in the same cycle frees the slot, so a full FIFO still accepts
   assign do_push = push && !flush && (!full || do_pop);
   assign rdata   = mem[rd_ptr];

   // pointer and occupancy bookkeeping
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (do_pop)
            rd_ptr <= rd_ptr + AW'(1);
         if (flush) begin
            wr_ptr <= empty ? rd_ptr : rd_ptr + AW'(1);
            cnt    <= (empty || do_pop) ? '0 : (AW+1)'(1);
         end else begin
            if (do_push)
               wr_ptr <= wr_ptr + AW'(1);
            case ({do_push, do_pop})
               2'b10:   cnt <= cnt + (AW+1)'(1);
               2'b01:   cnt <= cnt - (AW+1)'(1);
               default: cnt <= cnt;
            endcase
         end
      end
   end

   // entry storage (data only, no reset)
   always_ff @(posedge clk) begin
      if (do_push)
         mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/control_dispatch.sv
// SPI-target command front-end: deframes header + payload from a mode-0 SPI
// link, buffers payload bytes and streams them to the addressed accelerator
// channel. A status byte is shifted out on poci during every byte.
// Optional feature macro: CTRL_PARITY_EN (XOR trailer byte after the payload).
module control_dispatch
   import control_pkg::*;
#(
   parameter int NUM_CH     = 2,
   parameter int ID_W       = 2,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              spi_clk,
   input  logic              cs_n,
   input  logic              pico,
   output logic              poci,
   output logic [NUM_CH-1:0] ch_valid,
   input  logic [NUM_CH-1:0] ch_ready,
   output logic [7:0]        ch_data,
   output logic              ch_last,
   output logic [4:0]        err_flags
);

   localparam int LEN_W = 8 - ID_W;

   logic spi_clk_p0, spi_clk_p1, spi_clk_p2;
   logic cs_n_p0, cs_n_p1, cs_n_p2;
   logic pico_p0, pico_p1;
   logic sclk_rise, sclk_fall, cs_fall, cs_rise, cs_act;

   logic [2:0] bit_cnt;
   logic [7:0] rx_sh;
   logic [7:0] rx_byte;
   logic       rx_done;
   logic [7:0] tx_sh;
   logic [7:0] status_byte;

   state_t            state, next_state;
   logic [ID_W-1:0]   rx_id;
   logic [ID_W-1:0]   disp_id;
   logic [LEN_W-1:0]  hdr_len;
   logic [LEN_W-1:0]  pay_cnt;
   logic              term;
   logic              ovf, abort, bad_id, par_err, busy;

   logic fifo_push, fifo_pop, fifo_flush, push_last;
   logic fifo_full, fifo_empty, fifo_single;
   logic [8:0] fifo_rdata;
   logic set_ovf, set_abort, set_bad_id, clr_flags, enter_pay, pay_end;
`ifdef CTRL_PARITY_EN
   logic       set_par;
   logic [7:0] par_acc;
`endif

   // two-flop synchronizers plus one history flop for edge detection
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         spi_clk_p0 <= 1'b0;
         spi_clk_p1 <= 1'b0;
         spi_clk_p2 <= 1'b0;
         cs_n_p0    <= 1'b1;
         cs_n_p1    <= 1'b1;
         cs_n_p2    <= 1'b1;
         pico_p0    <= 1'b0;
         pico_p1    <= 1'b0;
      end else begin
         spi_clk_p0 <= spi_clk;
         spi_clk_p1 <= spi_clk_p0;
         spi_clk_p2 <= spi_clk_p1;
         cs_n_p0    <= cs_n;
         cs_n_p1    <= cs_n_p0;
         cs_n_p2    <= cs_n_p1;
         pico_p0    <= pico;
         pico_p1    <= pico_p0;
      end
   end

   assign sclk_rise = spi_clk_p1 && !spi_clk_p2;
   assign sclk_fall = !spi_clk_p1 && spi_clk_p2;
   assign cs_fall   = !cs_n_p1 && cs_n_p2;
   assign cs_rise   = cs_n_p1 && !cs_n_p2;
   assign cs_act    = !cs_n_p1;
   assign rx_id     = rx_byte[7 -: ID_W];

   // bit counter and byte-complete strobe (one clk after the 8th edge)
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bit_cnt <= 3'd0;
         rx_done <= 1'b0;
      end else begin
         rx_done <= 1'b0;
         if (cs_fall)
            bit_cnt <= 3'd0;
         else if (sclk_rise && cs_act) begin
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7)
               rx_done <= 1'b1;
         end
      end
   end

   // receive shift register and completed byte (data only, no reset)
   always_ff @(posedge clk) begin
      if (sclk_rise && cs_act) begin
         rx_sh <= {rx_sh[6:0], pico_p1};
         if (bit_cnt == 3'd7)
            rx_byte <= {rx_sh[6:0], pico_p1};
      end
   end

   assign busy        = !fifo_empty;
   assign status_byte = {busy, ovf, abort, bad_id, par_err, 3'b000};

   // status shifter: load at each byte start, shift on spi_clk falling edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         tx_sh <= 8'h00;
      else if (cs_fall)
         tx_sh <= status_byte;
      else if (sclk_fall && cs_act)
         tx_sh <= (bit_cnt == 3'd0) ? status_byte : {tx_sh[6:0], 1'b0};
   end

   assign poci = tx_sh[7];

   // frame FSM: next state and per-cycle FIFO/flag controls
   always_comb begin
      next_state = state;
      fifo_push  = 1'b0;
      fifo_flush = 1'b0;
      push_last  = 1'b0;
      set_ovf    = 1'b0;
      set_abort  = 1'b0;
      set_bad_id = 1'b0;
      clr_flags  = 1'b0;
      enter_pay  = 1'b0;
      pay_end    = 1'b0;
`ifdef CTRL_PARITY_EN
      set_par    = 1'b0;
`endif
      if (cs_rise) begin
         next_state = ST_IDLE;
         if (state == ST_PAYLOAD) begin
            set_abort  = 1'b1;
            fifo_flush = 1'b1;
         end
      end else begin
         case (state)
            ST_IDLE: begin
               if (cs_fall)
                  next_state = ST_HDR;
            end
            ST_HDR: begin
               if (rx_done) begin
                  if (rx_id == '0) begin
                     next_state = ST_STATUS;
                     clr_flags  = 1'b1;
                  end else if (rx_id > ID_W'(NUM_CH)) begin
                     next_state = ST_DISCARD;
                     set_bad_id = 1'b1;
                  end else if (!fifo_empty) begin
                     // previous frame still draining: this payload is dropped
                     next_state = ST_DISCARD;
                     set_ovf    = 1'b1;
                  end else begin
                     next_state = ST_PAYLOAD;
                     enter_pay  = 1'b1;
                  end
               end
            end
            ST_PAYLOAD: begin
               if (rx_done) begin
                  push_last = (pay_cnt == hdr_len);
                  if (fifo_full && !fifo_pop)
                     set_ovf = 1'b1;
                  else
                     fifo_push = 1'b1;
                  if (push_last) begin
                     pay_end = 1'b1;
`ifdef CTRL_PARITY_EN
                     next_state = ST_PARITY;
`else
                     next_state = ST_IDLE;
`endif
                  end
               end
            end
`ifdef CTRL_PARITY_EN
            ST_PARITY: begin
               if (rx_done) begin
                  if (rx_byte != par_acc)
                     set_par = 1'b1;
                  next_state = ST_IDLE;
               end
            end
`endif
            default: next_state = state;
         endcase
      end
   end

   // FSM state and frame bookkeeping
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= ST_IDLE;
         disp_id <= '0;
         hdr_len <= '0;
         pay_cnt <= '0;
         term    <= 1'b0;
      end else begin
         state <= next_state;
         if (enter_pay) begin
            disp_id <= rx_id;
            hdr_len <= rx_byte[LEN_W-1:0];
            pay_cnt <= '0;
            term    <= 1'b0;
         end else if (state == ST_PAYLOAD && rx_done) begin
            pay_cnt <= pay_cnt + LEN_W'(1);
         end
         // no more pushes will follow: the tail entry closes the frame
         if (pay_end || set_abort)
            term <= 1'b1;
      end
   end

   // sticky error flags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf    <= 1'b0;
         abort  <= 1'b0;
         bad_id <= 1'b0;
      end else if (clr_flags) begin
         ovf    <= 1'b0;
         abort  <= 1'b0;
         bad_id <= 1'b0;
      end else begin
         if (set_ovf)
            ovf <= 1'b1;
         if (set_abort)
            abort <= 1'b1;
         if (set_bad_id)
            bad_id <= 1'b1;
      end
   end

`ifdef CTRL_PARITY_EN
   // running XOR of header and payload, and sticky parity error
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         par_acc <= 8'h00;
         par_err <= 1'b0;
      end else begin
         if (state == ST_HDR && rx_done)
            par_acc <= rx_byte;
         else if (state == ST_PAYLOAD && rx_done)
            par_acc <= par_acc ^ rx_byte;
         if (clr_flags)
            par_err <= 1'b0;
         else if (set_par)
            par_err <= 1'b1;
      end
   end
`else
   assign par_err = 1'b0;
`endif

   ctrl_byte_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk    (clk),
      .rst_n  (rst_n),
      .push   (fifo_push),
      .wdata  ({push_last, rx_byte}),
      .pop    (fifo_pop),
      .flush  (fifo_flush),
      .rdata  (fifo_rdata),
      .full   (fifo_full),
      .empty  (fifo_empty),
      .single (fifo_single)
   );

   // one-hot valid toward the channel owning the buffered frame
   always_comb begin
      ch_valid = '0;
      for (int i = 0; i < NUM_CH; i++)
         ch_valid[i] = !fifo_empty && (disp_id == ID_W'(i + 1));
   end

   assign fifo_pop  = |(ch_valid & ch_ready);
   assign ch_data   = fifo_empty ? 8'h00 : fifo_rdata[7:0];
   // the final remaining entry of a terminated frame is always marked last
   assign ch_last   = !fifo_empty && (fifo_rdata[8] || (term && fifo_single));
   assign err_flags = {ovf, abort, bad_id, par_err, busy};

endmodule

// File: tb/tb_control_dispatch.sv
// Directed bench for control_dispatch: SPI host tasks drive framed commands,
// a channel monitor records accepted bytes, and every comparison goes
// through a single check task.
module tb_control_dispatch;

   localparam int NUM_CH = 2;

   logic              clk     = 1'b0;
   logic              rst_n   = 1'b0;
   logic              spi_clk = 1'b0;
   logic              cs_n    = 1'b1;
   logic              pico    = 1'b0;
   logic              poci;
   logic [NUM_CH-1:0] ch_valid;
   logic [NUM_CH-1:0] ch_ready = '0;
   logic [7:0]        ch_data;
   logic              ch_last;
   logic [4:0]        err_flags;

   int checks = 0;
   int errors = 0;

   logic [7:0]        tx_q[$];
   logic [7:0]        got_data[$];
   logic              got_last[$];
   logic [NUM_CH-1:0] got_vld[$];
   logic [7:0]        exp_d[$];
   logic              exp_l[$];
   logic [7:0]        st;

   control_dispatch #(
      .NUM_CH     (NUM_CH),
      .ID_W       (2),
      .FIFO_DEPTH (4)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .spi_clk   (spi_clk),
      .cs_n      (cs_n),
      .pico      (pico),
      .poci      (poci),
      .ch_valid  (ch_valid),
      .ch_ready  (ch_ready),
      .ch_data   (ch_data),
      .ch_last   (ch_last),
      .err_flags (err_flags)
   );

   always #5 clk = ~clk;

   // record every accepted channel transfer
   always @(negedge clk) begin
      if (|(ch_valid & ch_ready)) begin
         got_data.push_back(ch_data);
         got_last.push_back(ch_last);
         got_vld.push_back(ch_valid);
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
      rx = '0;
      for (int i = 7; i >= 0; i--) begin
         pico = tx[i];
         #40 spi_clk = 1'b1;
         rx = {rx[6:0], poci};
         #40 spi_clk = 1'b0;
      end
   endtask

   task automatic send_frame(output logic [7:0] hdr_rx);
      logic [7:0] r;
      hdr_rx = '0;
      cs_n = 1'b0;
      #80;
      foreach (tx_q[i]) begin
         spi_byte(tx_q[i], r);
         if (i == 0)
            hdr_rx = r;
      end
      #80 cs_n = 1'b1;
      #160;
   endtask

   task automatic read_status(output logic [7:0] s);
      tx_q = '{8'h00};
      send_frame(s);
   endtask

   task automatic set_ready(input logic [NUM_CH-1:0] v);
      @(posedge clk);
      #2 ch_ready = v;
      @(negedge clk);
   endtask

   task automatic clear_got();
      got_data.delete();
      got_last.delete();
      got_vld.delete();
   endtask

   task automatic check_stream(input string tag, input logic [NUM_CH-1:0] exp_v);
      check({tag, "_count"}, 32'(got_data.size()), 32'(exp_d.size()));
      for (int i = 0; i < exp_d.size() && i < got_data.size(); i++) begin
         check($sformatf("%s_data%0d", tag, i), 32'(got_data[i]), 32'(exp_d[i]));
         check($sformatf("%s_last%0d", tag, i), 32'(got_last[i]), 32'(exp_l[i]));
         check($sformatf("%s_vld%0d", tag, i), 32'(got_vld[i]), 32'(exp_v));
      end
   endtask

   initial begin
      #500000;
      $display("FAIL timeout checks=%0d", checks);
      $fatal(1, "timeout");
   end

   initial begin
      repeat (3) @(negedge clk);
      check("rst_valid", 32'(ch_valid), 32'(0));
      check("rst_data", 32'(ch_data), 32'(0));
      check("rst_last", 32'(ch_last), 32'(0));
      check("rst_err", 32'(err_flags), 32'(0));
      check("rst_poci", 32'(poci), 32'(0));
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // basic frame to ch0 with ready held high
      set_ready(2'b01);
      clear_got();
      tx_q = '{8'h42, 8'hA1, 8'hB2, 8'hC3};
      send_frame(st);
      repeat (10) @(negedge clk);
      check("t1_status", 32'(st), 32'h00);
      exp_d = '{8'hA1, 8'hB2, 8'hC3};
      exp_l = '{1'b0, 1'b0, 1'b1};
      check_stream("t1", 2'b01);
      check("t1_err", 32'(err_flags), 32'(0));

      // frame to ch1 held in FIFO, then drained
      set_ready(2'b00);
      clear_got();
      tx_q = '{8'h83, 8'h11, 8'h22, 8'h33, 8'h44};
      send_frame(st);
      check("t2_valid", 32'(ch_valid), 32'(2'b10));
      check("t2_data", 32'(ch_data), 32'h11);
      check("t2_last", 32'(ch_last), 32'(0));
      check("t2_err", 32'(err_flags), 32'(5'b00001));
      repeat (20) @(negedge clk);
      check("t2_hold", 32'(ch_data), 32'h11);
      set_ready(2'b10);
      repeat (20) @(negedge clk);
      exp_d = '{8'h11, 8'h22, 8'h33, 8'h44};
      exp_l = '{1'b0, 1'b0, 1'b0, 1'b1};
      check_stream("t2", 2'b10);
      check("t2_err_end", 32'(err_flags), 32'(0));

      // overflow: 6 bytes into a 4-deep FIFO with no consumer
      set_ready(2'b00);
      clear_got();
      tx_q = '{8'h45, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
      send_frame(st);
      check("t3_valid", 32'(ch_valid), 32'(2'b01));
      check("t3_data", 32'(ch_data), 32'h01);
      check("t3_err", 32'(err_flags), 32'(5'b10001));
      set_ready(2'b01);
      repeat (20) @(negedge clk);
      exp_d = '{8'h01, 8'h02, 8'h03, 8'h04};
      exp_l = '{1'b0, 1'b0, 1'b0, 1'b1};
      check_stream("t3", 2'b01);
      read_status(st);
      check("t3_status_ovf", 32'(st), 32'h40);
      check("t3_err_clr", 32'(err_flags), 32'(0));
      read_status(st);
      check("t3_status_clr", 32'(st), 32'h00);

      // unknown channel ID
      clear_got();
      tx_q = '{8'hC0, 8'h55};
      send_frame(st);
      check("t4_valid", 32'(ch_valid), 32'(0));
      check("t4_count", 32'(got_data.size()), 32'(0));
      check("t4_err", 32'(err_flags), 32'(5'b00100));
      read_status(st);
      check("t4_status", 32'(st), 32'h10);

      // abort after 2 of 5 payload bytes
      set_ready(2'b00);
      clear_got();
      tx_q = '{8'h44, 8'hAA, 8'hBB};
      send_frame(st);
      check("t5_valid", 32'(ch_valid), 32'(2'b01));
      check("t5_data", 32'(ch_data), 32'hAA);
      check("t5_last", 32'(ch_last), 32'(1));
      check("t5_err", 32'(err_flags), 32'(5'b01001));
      set_ready(2'b01);
      repeat (20) @(negedge clk);
      exp_d = '{8'hAA};
      exp_l = '{1'b1};
      check_stream("t5", 2'b01);
      check("t5_valid_end", 32'(ch_valid), 32'(0));
      read_status(st);
      check("t5_status", 32'(st), 32'h20);

`ifdef CTRL_PARITY_EN
      // wrong trailer, then correct trailer (0x41^0x12^0x34 = 0x67)
      clear_got();
      tx_q = '{8'h41, 8'h12, 8'h34, 8'h00};
      send_frame(st);
      repeat (10) @(negedge clk);
      exp_d = '{8'h12, 8'h34};
      exp_l = '{1'b0, 1'b1};
      check_stream("t6_bad", 2'b01);
      check("t6_par_err", 32'(err_flags), 32'(5'b00010));
      read_status(st);
      check("t6_status", 32'(st), 32'h08);
      clear_got();
      tx_q = '{8'h41, 8'h12, 8'h34, 8'h67};
      send_frame(st);
      repeat (10) @(negedge clk);
      check_stream("t6_good", 2'b01);
      check("t6_par_ok", 32'(err_flags), 32'(0));
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
